// File: rtl/vc_alloc_rr.sv
// Virtual-channel allocator: per-output round-robin arbitration among requesting inputs,
// lowest-free-VC selection, and authoritative busy tracking with tail-flit release.
module vc_alloc_rr #(
    parameter int PORT_NUM = 5,
    parameter int VC_NUM   = 4,
    parameter int VW       = $clog2(VC_NUM)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PORT_NUM-1:0]        req,
    input  logic [3*PORT_NUM-1:0]      route_sel,
    input  logic [PORT_NUM-1:0]        rel_valid,
    input  logic [VW*PORT_NUM-1:0]     rel_vc,
    output logic [PORT_NUM-1:0]        gnt,
    output logic [VW*PORT_NUM-1:0]     gnt_vc,
    output logic [VC_NUM*PORT_NUM-1:0] vc_busy,
    output logic                       rel_err
);

    localparam int PW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

    logic [PORT_NUM-1:0]        gnt_q, gnt_d;
    logic [VW*PORT_NUM-1:0]     gnt_vc_q, gnt_vc_d;
    logic [VC_NUM*PORT_NUM-1:0] busy_q, busy_d;
    logic                       rel_err_q, rel_err_d;
    logic [PW-1:0]              ptr_q [PORT_NUM];
    logic [PW-1:0]              ptr_d [PORT_NUM];
    logic [PORT_NUM-1:0]        elig;

    // An input is masked in its own grant cycle because req is still high then.
    always_comb begin
        elig = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            elig[i] = req[i] && (int'(route_sel[i*3 +: 3]) < PORT_NUM) && !gnt_q[i];
        end
    end

    always_comb begin
        int   idx;
        int   win;
        int   vsel;
        int   rv;
        logic found;
        logic freef;

        gnt_d     = '0;
        gnt_vc_d  = '0;
        busy_d    = busy_q;
        rel_err_d = 1'b0;
        for (int o = 0; o < PORT_NUM; o++) begin
            ptr_d[o] = ptr_q[o];
        end

        for (int o = 0; o < PORT_NUM; o++) begin
            // Releases act on the registered map; they are never bypassed into this cycle's arbitration.
            rv = int'(rel_vc[o*VW +: VW]);
            if (rel_valid[o] && (rv < VC_NUM)) begin
                if (busy_q[o*VC_NUM + rv]) begin
                    busy_d[o*VC_NUM + rv] = 1'b0;
                end else begin
                    rel_err_d = 1'b1;
                end
            end

            found = 1'b0;
            win   = 0;
            for (int k = 0; k < PORT_NUM; k++) begin
                idx = int'(ptr_q[o]) + k;
                if (idx >= PORT_NUM) begin
                    idx = idx - PORT_NUM;
                end
                if (!found && elig[idx] && (int'(route_sel[idx*3 +: 3]) == o)) begin
                    found = 1'b1;
                    win   = idx;
                end
            end

            freef = 1'b0;
            vsel  = 0;
            for (int j = 0; j < VC_NUM; j++) begin
                if (!freef && !busy_q[o*VC_NUM + j]) begin
                    freef = 1'b1;
                    vsel  = j;
                end
            end

            // A busy VC cannot be picked, so a same-cycle release on another VC never collides here.
            if (found && freef) begin
                gnt_d[win]                = 1'b1;
                gnt_vc_d[win*VW +: VW]    = VW'(vsel);
                busy_d[o*VC_NUM + vsel]   = 1'b1;
                ptr_d[o]                  = PW'((win + 1) % PORT_NUM);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q     <= '0;
            gnt_vc_q  <= '0;
            busy_q    <= '0;
            rel_err_q <= 1'b0;
            for (int o = 0; o < PORT_NUM; o++) begin
                ptr_q[o] <= '0;
            end
        end else begin
            gnt_q     <= gnt_d;
            gnt_vc_q  <= gnt_vc_d;
            busy_q    <= busy_d;
            rel_err_q <= rel_err_d;
            for (int o = 0; o < PORT_NUM; o++) begin
                ptr_q[o] <= ptr_d[o];
            end
        end
    end

    assign gnt     = gnt_q;
    assign gnt_vc  = gnt_vc_q;
    assign vc_busy = busy_q;
    assign rel_err = rel_err_q;

endmodule

// File: tb/tb_vc_alloc_rr.sv
// Directed bench for vc_alloc_rr: grant latency, round-robin fairness, VC exhaustion/release,
// parallel outputs, release errors, invalid routes and mid-stream reset.
module tb_vc_alloc_rr;

    logic        clk;
    logic        rst;
    logic [4:0]  req;
    logic [14:0] route_sel;
    logic [4:0]  rel_valid;
    logic [9:0]  rel_vc;
    logic [4:0]  gnt;
    logic [9:0]  gnt_vc;
    logic [19:0] vc_busy;
    logic        rel_err;

    int n_tests = 0;
    int n_fail  = 0;

    vc_alloc_rr #(.PORT_NUM(5), .VC_NUM(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .route_sel (route_sel),
        .rel_valid (rel_valid),
        .rel_vc    (rel_vc),
        .gnt       (gnt),
        .gnt_vc    (gnt_vc),
        .vc_busy   (vc_busy),
        .rel_err   (rel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_route(input int i, input int o);
        route_sel[i*3 +: 3] = 3'(o);
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        route_sel = '0;
        rel_valid = '0;
        rel_vc    = '0;
        #1;
        check("rst_gnt",     32'(gnt),     0);
        check("rst_gnt_vc",  32'(gnt_vc),  0);
        check("rst_busy",    32'(vc_busy), 0);
        check("rst_rel_err", 32'(rel_err), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single request: input 0 -> output 2
        set_route(0, 2);
        req = 5'b00001;
        tick();
        check("single_gnt",    32'(gnt),            32'h01);
        check("single_vc",     32'(gnt_vc[1:0]),    0);
        check("single_busy2",  32'(vc_busy[11:8]),  32'h1);
        tick();
        check("single_nodbl",  32'(gnt),            0);
        check("single_busy2b", 32'(vc_busy[11:8]),  32'h1);
        req = '0;
        tick();

        // Contention: inputs 0,1,3 -> output 4
        set_route(0, 4);
        set_route(1, 4);
        set_route(3, 4);
        req = 5'b01011;
        tick();
        check("cont_g0",  32'(gnt),         32'h01);
        check("cont_v0",  32'(gnt_vc[1:0]), 0);
        req[0] = 1'b0;
        tick();
        check("cont_g1",  32'(gnt),         32'h02);
        check("cont_v1",  32'(gnt_vc[3:2]), 1);
        req[1] = 1'b0;
        tick();
        check("cont_g3",  32'(gnt),         32'h08);
        check("cont_v3",  32'(gnt_vc[7:6]), 2);
        req[3] = 1'b0;
        tick();
        // Pointer now at 4: input 4 beats input 0
        set_route(4, 4);
        req = 5'b10001;
        tick();
        check("ptr4_gnt", 32'(gnt),         32'h10);
        check("ptr4_vc",  32'(gnt_vc[9:8]), 3);
        req[4] = 1'b0;
        tick();
        check("full4_nogrant", 32'(gnt),            0);
        check("full4_busy",    32'(vc_busy[19:16]), 32'hF);
        req = '0;
        tick();

        // Exhaustion of output 1 then release
        set_route(0, 1);
        for (int n = 0; n < 4; n++) begin
            req = 5'b00001;
            tick();
            check("fill_gnt", 32'(gnt),         32'h01);
            check("fill_vc",  32'(gnt_vc[1:0]), 32'(n));
            req = '0;
            tick();
        end
        check("fill_busy1", 32'(vc_busy[7:4]), 32'hF);
        set_route(2, 1);
        req = 5'b00100;
        tick();
        check("exh_nogrant", 32'(gnt), 0);
        rel_valid    = 5'b00010;
        rel_vc[3:2]  = 2'd2;
        tick();
        check("exh_nobypass", 32'(gnt),           0);
        check("exh_rel_busy", 32'(vc_busy[7:4]),  32'hB);
        rel_valid = '0;
        tick();
        check("exh_gnt",   32'(gnt),           32'h04);
        check("exh_vc",    32'(gnt_vc[5:4]),   2);
        check("exh_busy",  32'(vc_busy[7:4]),  32'hF);
        req = '0;

        // Mid-stream reset with a grant pulse in flight
        set_route(3, 0);
        req = 5'b01000;
        tick();
        check("pre_rst_gnt", 32'(gnt), 32'h08);
        req = '0;
        rst = 1'b1;
        #1;
        check("mrst_gnt",     32'(gnt),     0);
        check("mrst_gnt_vc",  32'(gnt_vc),  0);
        check("mrst_busy",    32'(vc_busy), 0);
        check("mrst_rel_err", 32'(rel_err), 0);
        tick();
        rst = 1'b0;
        tick();

        // Parallel outputs: input i -> output 4-i
        for (int i = 0; i < 5; i++) set_route(i, 4 - i);
        req = 5'b11111;
        tick();
        check("par_gnt",    32'(gnt),     32'h1F);
        check("par_gnt_vc", 32'(gnt_vc),  0);
        check("par_busy",   32'(vc_busy), 32'h11111);
        req = '0;
        tick();
        check("par_after",  32'(gnt),     0);

        // Release of a free VC
        rel_valid   = 5'b00001;
        rel_vc[1:0] = 2'd3;
        tick();
        check("relerr_pulse", 32'(rel_err), 1);
        check("relerr_busy",  32'(vc_busy), 32'h11111);
        rel_valid = '0;
        tick();
        check("relerr_once",  32'(rel_err), 0);

        // Same-edge release of vc0 and allocation on output 0
        rel_valid   = 5'b00001;
        rel_vc[1:0] = 2'd0;
        set_route(1, 0);
        req = 5'b00010;
        tick();
        check("sim_gnt",  32'(gnt),          32'h02);
        check("sim_vc",   32'(gnt_vc[3:2]),  1);
        check("sim_busy", 32'(vc_busy[3:0]), 32'h2);
        check("sim_err",  32'(rel_err),      0);
        rel_valid = '0;
        req = '0;
        tick();

        // Invalid route is ignored indefinitely
        set_route(2, 7);
        req = 5'b00100;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("inv_nogrant", 32'(gnt),     0);
            check("inv_noerr",   32'(rel_err), 0);
        end
        check("inv_busy", 32'(vc_busy), 32'h11112);
        req = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
